cu: RTL and testbench
=====================

CU -- requirements
Module: cu

Interface
REQ-001 SHALL have no parameters; register count 8 and register width 16 are fixed.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port INSTRUCTION, input, 48 bits: instruction executed every clock edge.
REQ-005 SHALL have port REGISTER_OUTPUT_DATA_BUS, output, 128 bits: register Rk packed at bits [16k+15:16k], k=0..7.

Function
REQ-006 SHALL decode the instruction fields as follows:
- OPCODE [47:45]
- RD_RE [44:42] (real-result register index)
- RD_IM [41:39] (imaginary-result register index)
- A [38:30] (operand 1 real)
- B [29:21] (operand 1 imaginary)
- C [20:12] (operand 2 real)
- D [11:3] (operand 2 imaginary)
- [2:0] reserved and ignored.
REQ-007 SHALL treat A, B, C, D as 9-bit two's-complement values (bit 8 = sign) and sign-extend them before arithmetic.
REQ-008 SHALL compute, for OPCODE 000 (complex add): RE = A + C, IM = B + D.
REQ-009 SHALL compute, for OPCODE 001 (complex subtract): RE = A - C, IM = B - D.
REQ-010 SHALL compute, for OPCODE 010 (complex multiply): RE = A*C - B*D, IM = A*D + B*C.
- Multiply uses full-precision signed arithmetic.
- The result is then truncated to the low 16 bits (wrap-around, no saturation).
REQ-011 SHALL compute, for OPCODE 011 (load): RE = sign-extended A, IM = sign-extended B; C and D are ignored.
REQ-012 SHALL treat OPCODES 100-111 as NOP: no register changes.
REQ-013 SHALL write, for OPCODES 000-011 on each rising CLK edge with RESET low: R[RD_RE] <= RE[15:0] and R[RD_IM] <= IM[15:0].
REQ-014 SHALL give the IM write priority when RD_RE == RD_IM, so only IM is stored.
REQ-015 SHALL keep all registers not addressed by RD_RE or RD_IM unchanged.
REQ-016 SHALL have a latency of one cycle: results appear on REGISTER_OUTPUT_DATA_BUS immediately after the executing edge.
REQ-017 SHALL drive REGISTER_OUTPUT_DATA_BUS combinationally from the registers only (no combinational path from INSTRUCTION).
REQ-018 SHALL have no handshake: every edge executes the current INSTRUCTION.
REQ-019 SHALL sum additions and subtractions in at least 10 bits; results are always representable in 16 bits.

Reset
REQ-020 SHALL clear all eight registers to 16'h0000 on a rising CLK edge with RESET high, so REGISTER_OUTPUT_DATA_BUS reads 128'h0.
REQ-021 SHALL give RESET priority over any instruction on the same edge.
REQ-022 SHALL let asserting RESET mid-sequence discard all prior results; no instruction is pending after reset.
REQ-023 SHALL, before the first reset, hold register contents unspecified; the bench resets first.

Verification
REQ-024 SHALL pass reset:
- RESET=1 for one edge with any INSTRUCTION.
- Required: bus = 128'h0.
REQ-025 SHALL pass add:
- From reset, one edge with INSTRUCTION = 000_010_100_0_0000_1100_0_0000_0110_0_0000_0010_0_0000_0100_000 (A=12, B=6, C=2, D=4).
- Required: R2=000E, R4=000A.
- Required: bus = 128'h0000_0000_0000_000A_0000_000E_0000_0000.
REQ-026 SHALL pass subtract with negative result:
- OPCODE 001, RD_RE=0, RD_IM=1, A=2, B=3, C=5, D=-4 (9'h1FC).
- Required: R0=FFFD, R1=0007.
REQ-027 SHALL pass multiply:
- OPCODE 010, RD_RE=6, RD_IM=7, A=3, B=2, C=1, D=4.
- Required: R6=FFFB (-5), R7=000E (14).
- Required: A=C=-256, B=D=0 gives R6=0000 (65536 wrapped).
REQ-028 SHALL pass NOP and collision:
- OPCODE 111 edge: bus unchanged.
- Load with RD_RE=RD_IM=3, A=1, B=-1: R3=FFFF.
REQ-029 SHALL pass reset priority:
- RESET=1 together with a valid add instruction.
- Required: bus = 128'h0.

Source files
------------

// File: rtl/cu.sv
// Complex-arithmetic unit: eight 16-bit registers, one instruction executed per clock.
module cu (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [47:0]  INSTRUCTION,
    output logic [127:0] REGISTER_OUTPUT_DATA_BUS
);

    localparam int unsigned NREG  = 8;
    localparam int unsigned RW    = 16;
    localparam int unsigned OW    = 9;
    localparam int unsigned AW    = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;

    logic [RW-1:0] regs_q [NREG];

    logic [2:0]    opcode;
    logic [2:0]    rd_re;
    logic [2:0]    rd_im;
    logic [OW-1:0] op_a;
    logic [OW-1:0] op_b;
    logic [OW-1:0] op_c;
    logic [OW-1:0] op_d;
    logic          unused_rsvd;

    assign opcode      = INSTRUCTION[47:45];
    assign rd_re       = INSTRUCTION[44:42];
    assign rd_im       = INSTRUCTION[41:39];
    assign op_a        = INSTRUCTION[38:30];
    assign op_b        = INSTRUCTION[29:21];
    assign op_c        = INSTRUCTION[20:12];
    assign op_d        = INSTRUCTION[11:3];
    assign unused_rsvd = ^INSTRUCTION[2:0];

    // Sign-extend the 9-bit operands; 32 bits hold any product sum without overflow.
    logic signed [AW-1:0] a_s;
    logic signed [AW-1:0] b_s;
    logic signed [AW-1:0] c_s;
    logic signed [AW-1:0] d_s;

    assign a_s = {{(AW-OW){op_a[OW-1]}}, op_a};
    assign b_s = {{(AW-OW){op_b[OW-1]}}, op_b};
    assign c_s = {{(AW-OW){op_c[OW-1]}}, op_c};
    assign d_s = {{(AW-OW){op_d[OW-1]}}, op_d};

    logic signed [AW-1:0] re_full_c;
    logic signed [AW-1:0] im_full_c;
    logic                 wr_en_c;

    // Compute the real/imaginary results for the current opcode.
    always_comb begin
        re_full_c = '0;
        im_full_c = '0;
        wr_en_c   = 1'b0;
        case (opcode)
            OP_ADD: begin
                re_full_c = a_s + c_s;
                im_full_c = b_s + d_s;
                wr_en_c   = 1'b1;
            end
            OP_SUB: begin
                re_full_c = a_s - c_s;
                im_full_c = b_s - d_s;
                wr_en_c   = 1'b1;
            end
            OP_MUL: begin
                re_full_c = (a_s * c_s) - (b_s * d_s);
                im_full_c = (a_s * d_s) + (b_s * c_s);
                wr_en_c   = 1'b1;
            end
            OP_LOAD: begin
                re_full_c = a_s;
                im_full_c = b_s;
                wr_en_c   = 1'b1;
            end
            default: begin
                wr_en_c = 1'b0;
            end
        endcase
    end

    // Register file update; the IM write comes last so it wins on a shared index.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs_q[rd_re] <= RW'(re_full_c);
            regs_q[rd_im] <= RW'(im_full_c);
        end
    end

    // Pack the register file onto the output bus, R0 in the low bits.
    always_comb begin
        REGISTER_OUTPUT_DATA_BUS = '0;
        for (int k = 0; k < NREG; k++) begin
            REGISTER_OUTPUT_DATA_BUS[k*RW +: RW] = regs_q[k];
        end
    end

endmodule

// File: tb/tb_cu.sv
// Scoreboard bench for cu: driver pushes expected bus values, monitor pops and compares.
module tb_cu;

    logic         clk;
    logic         rst;
    logic [47:0]  instr;
    logic [127:0] bus;

    cu dut (
        .CLK                      (clk),
        .RESET                    (rst),
        .INSTRUCTION              (instr),
        .REGISTER_OUTPUT_DATA_BUS (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] exp_q  [$];
    string        name_q [$];
    int           n_cmp;
    int           n_bad;
    bit           drv_done;

    // Reference register file held as plain integers.
    int model_r [8];

    function automatic int sx9(input logic [8:0] v);
        int t;
        t = int'(v);
        if (v[8]) t = t - 512;
        return t;
    endfunction

    function automatic logic [47:0] mk(input logic [2:0] op, input logic [2:0] rre,
                                       input logic [2:0] rim, input logic [8:0] a,
                                       input logic [8:0] b, input logic [8:0] c,
                                       input logic [8:0] d);
        return {op, rre, rim, a, b, c, d, 3'b000};
    endfunction

    function automatic logic [127:0] model_bus();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(model_r[k]);
        return v;
    endfunction

    // Apply the architectural effect of one edge to the reference model.
    task automatic model_step(input logic r, input logic [47:0] ins);
        int a, b, c, d, re, im;
        logic [2:0] op;
        op = ins[47:45];
        a = sx9(ins[38:30]); b = sx9(ins[29:21]);
        c = sx9(ins[20:12]); d = sx9(ins[11:3]);
        if (r) begin
            for (int k = 0; k < 8; k++) model_r[k] = 0;
            return;
        end
        case (op)
            3'd0: begin re = a + c; im = b + d; end
            3'd1: begin re = a - c; im = b - d; end
            3'd2: begin re = a * c - b * d; im = a * d + b * c; end
            3'd3: begin re = a; im = b; end
            default: return;
        endcase
        model_r[ins[44:42]] = re & 32'hFFFF;
        model_r[ins[41:39]] = im & 32'hFFFF;
    endtask

    // Drive one edge's inputs and queue the expected bus (hand value if given).
    task automatic issue(input logic r, input logic [47:0] ins, input string nm,
                         input bit use_fixed, input logic [127:0] fixed);
        @(posedge clk);
        #2;
        rst   = r;
        instr = ins;
        model_step(r, ins);
        exp_q.push_back(use_fixed ? fixed : model_bus());
        name_q.push_back(nm);
    endtask

    // Monitor: one result per edge, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [127:0] e;
                string        nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (bus !== e) begin
                    n_bad++;
                    $display("FAIL %s: bus=%h required=%h", nm, bus, e);
                end
            end
        end
    end

    // Stimulus: directed cases first, then randomized traffic with occasional resets.
    initial begin
        logic [47:0]  ins;
        logic [127:0] z;
        n_cmp    = 0;
        n_bad    = 0;
        drv_done = 0;
        rst      = 1'b0;
        instr    = '0;
        z        = '0;
        for (int k = 0; k < 8; k++) model_r[k] = 0;

        issue(1'b1, 48'hFFFF_FFFF_FFFF, "reset", 1, z);
        issue(1'b0, mk(3'd0, 3'd2, 3'd4, 9'd12, 9'd6, 9'd2, 9'd4), "add", 1,
              128'h0000_0000_0000_000A_0000_000E_0000_0000);
        issue(1'b0, mk(3'd1, 3'd0, 3'd1, 9'd2, 9'd3, 9'd5, 9'h1FC), "sub_neg", 1,
              128'h0000_0000_0000_000A_0000_000E_0007_FFFD);
        issue(1'b0, mk(3'd2, 3'd6, 3'd7, 9'd3, 9'd2, 9'd1, 9'd4), "mul", 1,
              128'h000E_FFFB_0000_000A_0000_000E_0007_FFFD);
        issue(1'b0, mk(3'd2, 3'd6, 3'd7, 9'h100, 9'd0, 9'h100, 9'd0), "mul_wrap", 1,
              128'h0000_0000_0000_000A_0000_000E_0007_FFFD);
        issue(1'b0, mk(3'd7, 3'd1, 3'd2, 9'd100, 9'd50, 9'd7, 9'd9), "nop", 1,
              128'h0000_0000_0000_000A_0000_000E_0007_FFFD);
        issue(1'b0, mk(3'd3, 3'd3, 3'd3, 9'd1, 9'h1FF, 9'd77, 9'd88), "load_collide", 1,
              128'h0000_0000_0000_000A_FFFF_000E_0007_FFFD);
        issue(1'b1, mk(3'd0, 3'd5, 3'd6, 9'd20, 9'd30, 9'd1, 9'd1), "reset_prio", 1, z);
        issue(1'b0, mk(3'd2, 3'd0, 3'd1, 9'h1FF, 9'h100, 9'h0FF, 9'h100), "mul_extreme", 0, z);
        issue(1'b0, mk(3'd0, 3'd5, 3'd5, 9'h100, 9'h100, 9'h100, 9'h100), "add_collide", 0, z);

        for (int i = 0; i < 400; i++) begin
            ins = {$urandom(), 16'($urandom())};
            if ($urandom_range(3) == 0) ins[38:30] = ($urandom_range(1) != 0) ? 9'h100 : 9'h0FF;
            if ($urandom_range(3) == 0) ins[11:3]  = ($urandom_range(1) != 0) ? 9'h100 : 9'h0FF;
            issue(($urandom_range(24) == 0), ins, $sformatf("rand%0d", i), 0, z);
        end
        drv_done = 1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        int waited;
        wait (drv_done);
        waited = 0;
        while (exp_q.size() > 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
